easy_axi_slv: RTL and testbench

AXI read-slave responder that sits directly downstream of the easy_axi read master. It accepts AR requests and returns single-beat R responses in order after a programmable latency, and flags out-of-range addresses with SLVERR. Up to OSTD_DEPTH requests may be outstanding. The block gives the master a complete AR/R counterpart for system simulation and bring-up.

---
 rtl/easy_axi_slv.sv | 147 ++++++++++++++
 tb/tb_easy_axi_slv.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/easy_axi_slv.sv
// ============================================================================
// Module   : easy_axi_slv
// Purpose  : AXI read-slave responder. Queues AR requests in a circular FIFO
//            and returns one single-beat R response per request, in request
//            order, once the head has waited RD_LATENCY cycles. Addresses at
//            or above ADDR_LIMIT are answered with SLVERR.
// Ports    : clk, rst_n                - clock, async active-low reset
//            axi_slv_ar{valid,ready,id,addr} - read request channel
//            axi_slv_r{valid,ready,id,data,resp,last} - read response channel
//            ostd_cnt                  - number of queued requests
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module easy_axi_slv #(
  parameter int                         OSTD_DEPTH = 4,
  parameter int                         RD_LATENCY = 2,
  parameter logic [`AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = 16'h0001
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              axi_slv_arvalid,
  output logic                              axi_slv_arready,
  input  logic [`AXI_ID_WIDTH-1:0]          axi_slv_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0]        axi_slv_araddr,
  output logic                              axi_slv_rvalid,
  input  logic                              axi_slv_rready,
  output logic [`AXI_ID_WIDTH-1:0]          axi_slv_rid,
  output logic [`AXI_DATA_WIDTH-1:0]        axi_slv_rdata,
  output logic [1:0]                        axi_slv_rresp,
  output logic                              axi_slv_rlast,
  output logic [$clog2(OSTD_DEPTH):0]       ostd_cnt
);

  localparam int c_IW    = `AXI_ID_WIDTH;
  localparam int c_AW    = `AXI_ADDR_WIDTH;
  localparam int c_DW    = `AXI_DATA_WIDTH;
  localparam int c_PTR_W = $clog2(OSTD_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(OSTD_DEPTH);
  localparam logic [3:0]         c_LAT  = 4'(RD_LATENCY);

  // Request storage (no reset needed: only entries below the count are read)
  logic [c_IW-1:0]    r_mem_id   [OSTD_DEPTH];
  logic [c_AW-1:0]    r_mem_addr [OSTD_DEPTH];

  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_wait;

  logic               w_arready;
  logic               w_rvalid;
  logic               w_push;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [3:0]         w_wait_nxt;
  logic [c_IW-1:0]    w_head_id;
  logic [c_AW-1:0]    w_head_addr;
  logic [c_DW-1:0]    w_rdata;

  // Both handshake qualifiers come from registers only, so neither ready
  // nor valid depends combinationally on the other side.
  assign w_arready   = (r_cnt != c_FULL);
  assign w_rvalid    = (r_cnt != '0) && (r_wait == 4'd0);
  assign w_push      = axi_slv_arvalid && w_arready;
  assign w_pop       = w_rvalid && axi_slv_rready;
  assign w_head_id   = r_mem_id[r_rptr];
  assign w_head_addr = r_mem_addr[r_rptr];

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + c_CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - c_CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // The wait counter restarts whenever a new entry becomes the head: either a
  // push into an empty queue, or a pop that exposes another entry (this also
  // covers push+pop at a count of one, where the pushed entry becomes head).
  always_comb begin
    w_wait_nxt = r_wait;
    if (w_push && (r_cnt == '0)) begin
      w_wait_nxt = c_LAT;
    end else if (w_pop && (w_cnt_nxt != '0)) begin
      w_wait_nxt = c_LAT;
    end else if ((r_wait != 4'd0) && (r_cnt != '0)) begin
      w_wait_nxt = r_wait - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_wait <= 4'd0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      r_cnt  <= w_cnt_nxt;
      r_wait <= w_wait_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wptr]   <= axi_slv_arid;
      r_mem_addr[r_wptr] <= axi_slv_araddr;
    end
  end

  // Payload: address in the top bits, ID in the bottom bits, zeros between.
  always_comb begin
    w_rdata = '0;
    if (w_rvalid) begin
      w_rdata[c_DW-1 -: c_AW] = w_head_addr;
      w_rdata[c_IW-1:0]       = w_head_id;
    end
  end

  assign axi_slv_arready = w_arready;
  assign axi_slv_rvalid  = w_rvalid;
  assign axi_slv_rlast   = w_rvalid;
  assign axi_slv_rid     = w_rvalid ? w_head_id : '0;
  assign axi_slv_rdata   = w_rdata;
  assign axi_slv_rresp   = !w_rvalid                 ? 2'b00 :
                           (w_head_addr < ADDR_LIMIT) ? 2'b00 : 2'b10;
  assign ostd_cnt        = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_easy_axi_slv.sv
// ============================================================================
// Module   : tb_easy_axi_slv
// Purpose  : Self-checking bench for easy_axi_slv. A queue-plus-timestamp
//            reference model predicts every R-channel output each cycle.
//            A second instance with zero latency covers the throughput case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_easy_axi_slv;

  localparam int IW    = `AXI_ID_WIDTH;
  localparam int AW    = `AXI_ADDR_WIDTH;
  localparam int DW    = `AXI_DATA_WIDTH;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam logic [AW-1:0] LIMIT = 16'h0001;

  typedef logic [AW+IW-1:0] ent_t;   // {addr, id}

  logic          clk;
  logic          rst_n;
  // main instance (latency 2)
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [IW-1:0] arid, rid;
  logic [AW-1:0] araddr;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [2:0]    ostd_cnt;
  // zero-latency instance
  logic          arvalid0, arready0, rvalid0, rready0, rlast0;
  logic [IW-1:0] arid0, rid0;
  logic [AW-1:0] araddr0;
  logic [DW-1:0] rdata0;
  logic [1:0]    rresp0;
  logic [2:0]    ostd_cnt0;

  int checks = 0;
  int errors = 0;

  // reference model state
  ent_t q[$];        // requests accepted, not yet answered
  ent_t req_q[$];    // requests the bench still wants to issue
  int   edges      = 0;
  int   head_since = 0;

  easy_axi_slv #(.OSTD_DEPTH(DEPTH), .RD_LATENCY(LAT), .ADDR_LIMIT(LIMIT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .axi_slv_arvalid(arvalid), .axi_slv_arready(arready),
    .axi_slv_arid(arid), .axi_slv_araddr(araddr),
    .axi_slv_rvalid(rvalid), .axi_slv_rready(rready),
    .axi_slv_rid(rid), .axi_slv_rdata(rdata), .axi_slv_rresp(rresp),
    .axi_slv_rlast(rlast), .ostd_cnt(ostd_cnt)
  );

  easy_axi_slv #(.OSTD_DEPTH(DEPTH), .RD_LATENCY(0), .ADDR_LIMIT(LIMIT)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .axi_slv_arvalid(arvalid0), .axi_slv_arready(arready0),
    .axi_slv_arid(arid0), .axi_slv_araddr(araddr0),
    .axi_slv_rvalid(rvalid0), .axi_slv_rready(rready0),
    .axi_slv_rid(rid0), .axi_slv_rdata(rdata0), .axi_slv_rresp(rresp0),
    .axi_slv_rlast(rlast0), .ostd_cnt(ostd_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a, input logic [IW-1:0] i);
    mk_data = (DW'(a) << (DW - AW)) | DW'(i);
  endfunction

  function automatic logic [1:0] mk_resp(input logic [AW-1:0] a);
    mk_resp = (a < LIMIT) ? 2'b00 : 2'b10;
  endfunction

  // One clock cycle on the main instance: present the next pending request,
  // compare all outputs with the model, clock, then advance the model.
  task automatic cycle();
    logic          ev, push, pop;
    ent_t          h;
    logic [AW-1:0] ha;
    logic [IW-1:0] hi;
    arvalid = (req_q.size() != 0);
    arid    = arvalid ? req_q[0][IW-1:0] : '0;
    araddr  = arvalid ? req_q[0][AW+IW-1:IW] : '0;
    // Head is presentable LAT edges after it became head.
    ev = (q.size() != 0) && (edges >= head_since + LAT);
    h  = (q.size() != 0) ? q[0] : '0;
    ha = h[AW+IW-1:IW];
    hi = h[IW-1:0];
    chk("arready",  64'(arready),  64'(q.size() != DEPTH));
    chk("rvalid",   64'(rvalid),   64'(ev));
    chk("rlast",    64'(rlast),    64'(ev));
    chk("rid",      64'(rid),      ev ? 64'(hi) : 64'(0));
    chk("rdata",    64'(rdata),    ev ? 64'(mk_data(ha, hi)) : 64'(0));
    chk("rresp",    64'(rresp),    ev ? 64'(mk_resp(ha)) : 64'(0));
    chk("ostd_cnt", 64'(ostd_cnt), 64'(q.size()));
    push = arvalid && (q.size() != DEPTH);
    pop  = ev && rready;
    @(posedge clk);
    edges++;
    if (pop) begin
      void'(q.pop_front());
      if (q.size() != 0) head_since = edges;
    end
    if (push) begin
      if (q.size() == 0) head_since = edges;
      q.push_back({araddr, arid});
      void'(req_q.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] addrs [18];
    rst_n = 1'b0;
    arvalid = 1'b0; arid = '0; araddr = '0; rready = 1'b0;
    arvalid0 = 1'b0; arid0 = '0; araddr0 = '0; rready0 = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_rvalid",  64'(rvalid),   64'(0));
    chk("rst_ostd",    64'(ostd_cnt), 64'(0));
    chk("rst_rdata",   64'(rdata),    64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_arready", 64'(arready),  64'(1));

    // ---- single request ----
    rready = 1'b1;
    req_q.push_back({16'h0000, 4'h3});
    repeat (3) cycle();
    chk("single_rvalid", 64'(rvalid), 64'(1));
    chk("single_rdata",  64'(rdata),  64'(32'h0000_0003));
    repeat (3) cycle();
    chk("single_ostd",   64'(ostd_cnt), 64'(0));

    // ---- error path ----
    req_q.push_back({16'h0001, 4'h1});
    repeat (5) cycle();
    req_q.push_back({16'h0005, 4'h9});
    repeat (5) cycle();

    // ---- full queue ----
    rready = 1'b0;
    for (int i = 0; i < 5; i++) req_q.push_back({16'(i * 16'h0101), 4'(i)});
    repeat (6) cycle();
    chk("full_ostd",    64'(ostd_cnt), 64'(4));
    chk("full_arready", 64'(arready),  64'(0));
    rready = 1'b1;
    repeat (20) cycle();

    // ---- backpressure with random data ----
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      req_q.push_back({a, 4'($urandom)});
    end
    for (int i = 0; i < 60; i++) begin
      rready = 1'($urandom_range(0, 1));
      cycle();
    end
    rready = 1'b1;
    repeat (30) cycle();
    chk("bp_drained", 64'(ostd_cnt), 64'(0));

    // ---- throughput / wrap-around on zero-latency instance ----
    rready0 = 1'b1;
    for (int k = 0; k < 16; k++) addrs[k] = 16'($urandom_range(0, 2));
    addrs[16] = '0; addrs[17] = '0;
    for (int k = 0; k < 18; k++) begin
      arvalid0 = (k < 16);
      arid0    = 4'(k);
      araddr0  = addrs[k];
      if (k < 16) chk("tp_arready", 64'(arready0), 64'(1));
      if (k >= 1 && k <= 16) begin
        chk("tp_rvalid", 64'(rvalid0),   64'(1));
        chk("tp_rid",    64'(rid0),      64'(k - 1));
        chk("tp_rdata",  64'(rdata0),    64'(mk_data(addrs[k-1], 4'(k - 1))));
        chk("tp_rresp",  64'(rresp0),    64'(mk_resp(addrs[k-1])));
        chk("tp_ostd",   64'(ostd_cnt0), 64'(1));
      end else begin
        chk("tp_idle",   64'(rvalid0),   64'(0));
        chk("tp_ostd0",  64'(ostd_cnt0), 64'(0));
      end
      cycle();
    end
    arvalid0 = 1'b0;

    // ---- reset mid-operation ----
    rready = 1'b0;
    for (int i = 0; i < 3; i++) req_q.push_back({16'h0000, 4'(i + 10)});
    repeat (5) cycle();
    chk("pre_rst_rvalid", 64'(rvalid),   64'(1));
    chk("pre_rst_ostd",   64'(ostd_cnt), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid",  64'(rvalid),   64'(0));
    chk("mid_rst_ostd",    64'(ostd_cnt), 64'(0));
    chk("mid_rst_arready", 64'(arready),  64'(1));
    chk("mid_rst_rid",     64'(rid),      64'(0));
    q.delete();
    req_q.delete();
    arvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rready = 1'b1;
    req_q.push_back({16'h0000, 4'h7});
    repeat (3) cycle();
    chk("post_rst_rid", 64'(rid), 64'(7));
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
